// File: rtl/blackjack_round_fsm_pkg.sv
// blackjack_round_fsm_pkg: shared state/winner encodings, limits and card helpers.
// Optional feature macro ACE_SOFT_EN: soft-ace hand tracking.
package blackjack_round_fsm_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        DEAL_P1     = 4'd1,
        DEAL_D1     = 4'd2,
        DEAL_P2     = 4'd3,
        DEAL_D2     = 4'd4,
        PLAYER_TURN = 4'd5,
        PLAYER_DRAW = 4'd6,
        DEALER_TURN = 4'd7,
        DEALER_DRAW = 4'd8,
        RESULT      = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        PLAYER = 2'b01,
        DEALER = 2'b10,
        PUSH   = 2'b11
    } winner_t;

    localparam logic [4:0] BUST_LIMIT = 5'd21;
    localparam logic [4:0] FACE_VALUE = 5'd10;

`ifdef ACE_SOFT_EN
    typedef struct packed {
        logic       soft;
        logic [4:0] total;
    } hand_t;
`else
    typedef struct packed {
        logic [4:0] total;
    } hand_t;
`endif

    function automatic logic [4:0] map_card(input logic [4:0] raw);
        return (raw == 5'd0) ? 5'd1 : (raw > FACE_VALUE) ? FACE_VALUE : raw;
    endfunction

    function automatic hand_t add_card(input hand_t h, input logic [4:0] raw);
        hand_t      r;
        logic [4:0] v;
        v = map_card(raw);
`ifdef ACE_SOFT_EN
        // total <= 10 is the wrap-free form of total + 11 <= 21
        if (v == 5'd1 && h.total <= BUST_LIMIT - 5'd11) begin
            r.total = h.total + 5'd11;
            r.soft  = 1'b1;
        end else begin
            r.total = h.total + v;
            r.soft  = h.soft;
            if (r.total > BUST_LIMIT && h.soft) begin
                r.total = r.total - FACE_VALUE;
                r.soft  = 1'b0;
            end
        end
`else
        r.total = h.total + v;
`endif
        return r;
    endfunction

    function automatic winner_t judge(input logic [4:0] p, input logic [4:0] d);
        return (p > BUST_LIMIT) ? DEALER :
               (d > BUST_LIMIT) ? PLAYER :
               (p > d)          ? PLAYER :
               (p < d)          ? DEALER : PUSH;
    endfunction

endpackage

// File: rtl/blackjack_round_fsm_key_pulse.sv
// key_pulse: registered falling-edge detector for an active-low raw key.
// Ports: clock, reset (sync, active-high), key_n (raw key), pulse (one-cycle press pulse).
module key_pulse (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);
    logic q, prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            q    <= 1'b1;
            prev <= 1'b1;
        end else begin
            q    <= key_n;
            prev <= q;
        end
    end

    assign pulse = prev & ~q;
endmodule

// File: rtl/blackjack_round_fsm.sv
// blackjack_round_fsm: one blackjack round (deal, player turn, dealer turn, result).
// Ports: clock, reset (sync, active-high); key_deal_n/key_hit_n/key_stand_n raw active-low keys;
// card_valid/card_value/card_ready card handshake; player_score, dealer_score, winner,
// round_done, state_out status outputs. Optional macro ACE_SOFT_EN enables soft aces.
module blackjack_round_fsm
    import blackjack_round_fsm_pkg::*;
#(
    parameter logic [4:0] DEALER_STAND = 5'd17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_deal_n,
    input  logic       key_hit_n,
    input  logic       key_stand_n,
    input  logic       card_valid,
    input  logic [4:0] card_value,
    output logic       card_ready,
    output logic [4:0] player_score,
    output logic [4:0] dealer_score,
    output logic [1:0] winner,
    output logic       round_done,
    output logic [3:0] state_out
);
    logic    deal, hit, stand, take;
    state_t  state, state_n;
    hand_t   player, player_n, dealer, dealer_n, p_add, d_add;
    winner_t win, win_n;

    key_pulse u_deal  (.clock(clock), .reset(reset), .key_n(key_deal_n),  .pulse(deal));
    key_pulse u_hit   (.clock(clock), .reset(reset), .key_n(key_hit_n),   .pulse(hit));
    key_pulse u_stand (.clock(clock), .reset(reset), .key_n(key_stand_n), .pulse(stand));

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            player <= '0;
            dealer <= '0;
            win    <= NONE;
        end else begin
            state  <= state_n;
            player <= player_n;
            dealer <= dealer_n;
            win    <= win_n;
        end
    end

    assign card_ready = state inside {DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_DRAW, DEALER_DRAW};
    assign take       = card_valid & card_ready;
    assign p_add      = add_card(player, card_value);
    assign d_add      = add_card(dealer, card_value);

    always_comb begin
        state_n  = state;
        player_n = player;
        dealer_n = dealer;
        win_n    = win;
        case (state)
            IDLE:        state_n = deal ? DEAL_P1 : IDLE;
            DEAL_P1:     if (take) begin player_n = p_add; state_n = DEAL_D1; end
            DEAL_D1:     if (take) begin dealer_n = d_add; state_n = DEAL_P2; end
            DEAL_P2:     if (take) begin player_n = p_add; state_n = DEAL_D2; end
            DEAL_D2:     if (take) begin dealer_n = d_add; state_n = PLAYER_TURN; end
            PLAYER_TURN: state_n = stand ? DEALER_TURN : hit ? PLAYER_DRAW : PLAYER_TURN;
            PLAYER_DRAW: if (take) begin
                player_n = p_add;
                if (p_add.total > BUST_LIMIT) begin
                    state_n = RESULT;
                    win_n   = judge(p_add.total, dealer.total);
                end else begin
                    state_n = PLAYER_TURN;
                end
            end
            DEALER_TURN: if (dealer.total < DEALER_STAND) begin
                state_n = DEALER_DRAW;
            end else begin
                state_n = RESULT;
                win_n   = judge(player.total, dealer.total);
            end
            DEALER_DRAW: if (take) begin dealer_n = d_add; state_n = DEALER_TURN; end
            RESULT:      if (deal) begin
                state_n  = DEAL_P1;
                player_n = '0;
                dealer_n = '0;
                win_n    = NONE;
            end
            default:     state_n = IDLE;
        endcase
    end

    assign player_score = player.total;
    assign dealer_score = dealer.total;
    assign winner       = win;
    assign round_done   = (state == RESULT);
    assign state_out    = state;
endmodule

// File: doc/blackjack_round_fsm.md
BLACKJACK_ROUND_FSM -- requirements
Module: blackjack_round_fsm

Interface
REQ-001 Parameter DEALER_STAND, default 17: the dealer draws while dealer_score < DEALER_STAND.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single system clock; all logic on posedge.
- reset, in, 1: synchronous, active-high reset.
- key_deal_n, in, 1: active-low raw deal key.
- key_hit_n, in, 1: active-low raw hit key.
- key_stand_n, in, 1: active-low raw stand key.
- card_valid, in, 1: card source presents card_value.
- card_value, in, 5: card rank, nominally 1..10.
- card_ready, out, 1: block requests a card.
- player_score, out, 5: player hand total.
- dealer_score, out, 5: dealer hand total.
- winner, out, 2: 00 none, 01 player, 10 dealer, 11 push.
- round_done, out, 1: high only in RESULT.
- state_out, out, 4: current state encoding, for debug and LEDs.

Function
REQ-003 The block SHALL convert each raw key to a one-cycle pulse on its high-to-low transition, with the input registered once before edge detection.
REQ-004 A card transfer SHALL occur only in a cycle where card_valid and card_ready are both 1; card_ready SHALL be 1 only in DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_DRAW and DEALER_DRAW.
REQ-005 Card values SHALL be mapped as follows: 0 counts as 1; 11..31 count as 10; 1..10 are used unchanged.
REQ-006 The affected score SHALL update on the clock edge that completes the transfer, and the FSM SHALL leave the draw state on that same edge.
REQ-007 Scores SHALL be 5-bit unsigned values; they cannot overflow because the maximum reachable total is 31.
REQ-008 FSM states and transitions:
- IDLE: on deal pulse, go to DEAL_P1.
- DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2: one transfer each, in that order.
- DEAL_D2 -> PLAYER_TURN.
- PLAYER_TURN: stand pulse -> DEALER_TURN; hit pulse -> PLAYER_DRAW.
- PLAYER_DRAW: after the transfer, go to RESULT if player_score > 21, otherwise back to PLAYER_TURN.
- DEALER_TURN: dealer_score < DEALER_STAND -> DEALER_DRAW; otherwise -> RESULT.
- DEALER_DRAW: after the transfer, go to DEALER_TURN.
- RESULT: on deal pulse, go to DEAL_P1 with both scores cleared and winner = 00 on that same edge.
REQ-009 winner SHALL be written on entry to RESULT, using the first rule that applies:
1. player > 21 -> 10 (dealer wins).
2. dealer > 21 -> 01 (player wins).
3. player > dealer -> 01.
4. player < dealer -> 10.
5. Equal -> 11 (push).
REQ-010 When player_score > 21, the FSM SHALL go to RESULT without any dealer draws.
REQ-011 If hit and stand pulse in the same cycle in PLAYER_TURN, stand SHALL take priority.
REQ-012 Key pulses SHALL be ignored in every state other than those listed in REQ-008, and SHALL NOT be queued.
REQ-013 card_valid held high outside the card_ready states SHALL have no effect.

Reset
REQ-014 While reset is 1 at a clock edge, the block SHALL go to IDLE with player_score = 0, dealer_score = 0, winner = 00, round_done = 0, card_ready = 0, and the key edge registers loaded with 1 (released).
REQ-015 Reset asserted mid-round, including during a draw, SHALL abort the round, and no card SHALL be accepted on that edge.

Configuration
REQ-016 Macro ACE_SOFT_EN:
- When defined: each hand keeps a soft flag. A mapped value of 1 adds 11 if the total stays at or below 21, and sets the flag. If a later card pushes the total above 21 while the flag is set, the block subtracts 10 and clears the flag.
- When undefined: an ace always counts as 1, and no soft-flag logic is synthesized.

Structure
REQ-017 A shared package SHALL hold:
- the state encoding (4 bits, 10 states);
- the winner codes NONE, PLAYER, DEALER, PUSH;
- the constants BUST_LIMIT = 21 and FACE_VALUE = 10.
REQ-018 The block SHALL contain one sub-module, key_pulse (a registered falling-edge detector), instantiated three times.

Verification
REQ-019 Basic round: deal, then cards 10,7,9,10 in order. Required: after DEAL_D2, player = 19 and dealer = 17; stand -> RESULT with no dealer draw and winner = 01.
REQ-020 Player bust: deal with cards 10,5,6,8, then hit with card 10. Required: player = 26, RESULT entered directly, winner = 10, card_ready never raised in DEALER_DRAW.
REQ-021 Dealer draw and bust: deal with cards 10,10,8,6, then stand. Required: dealer draws 9 (total 25), winner = 01. Then a push case: deal with cards 10,10,8,8, stand. Required: dealer = 18, winner = 11.
REQ-022 Handshake and priority:
- card_valid low for 5 cycles in DEAL_P1 -> state unchanged and scores 0.
- hit and stand pulsed in the same cycle -> DEALER_TURN.
- Reset asserted during PLAYER_DRAW -> IDLE, all outputs 0.
REQ-023 ACE_SOFT_EN: deal with cards 1,10,5,10, then hit with card 9. Required: player = 16 after the deal, 15 after the hit with the soft flag cleared. With the macro undefined, the same sequence gives 6, then 15.
